// File: rtl/nowcode_mul_pkg.sv
// Shared types and default widths for the round-robin multiplier scheduler.
package nowcode_mul_pkg;

    localparam int DW_DEF = 8;
    localparam int OW_DEF = 11;

    typedef enum logic [1:0] {
        PH_X1 = 2'd0,
        PH_X3 = 2'd1,
        PH_X7 = 2'd2,
        PH_X8 = 2'd3
    } phase_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/nowcode_rr_arb.sv
// Stateless rotate-priority picker: first set bit of req at or above ptr, wrapping.
module nowcode_rr_arb
    import nowcode_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = IDW'(cand);
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nowcode_mul_sched.sv
// Round-robin scheduler sharing one x{1,3,7,8} shift-add multiplier among N_REQ
// requesters; each grant yields four tagged results over a valid/ready port.
module nowcode_mul_sched
    import nowcode_mul_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] d,
    output logic [N_REQ-1:0]    gnt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OW-1:0]       out,
    output logic [IDW-1:0]      out_id,
    output logic [1:0]          out_phase,
    output logic                busy
);

    state_e             state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [DW-1:0]      op_q, op_d;
    logic [OW-1:0]      out_q, out_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;

    logic [N_REQ-1:0]   arb_onehot;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;
    logic [DW-1:0]      win_op;
    logic               accept;
    logic               launch;

    logic [OW-1:0]      op_ext;
    logic [OW-1:0]      x3;
    logic [OW-1:0]      x7;
    logic [OW-1:0]      x8;
    logic [OW-1:0]      step_val;

    nowcode_rr_arb #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    assign win_op = d[arb_idx*DW +: DW];
    assign accept = (state_q == S_RUN) && out_ready;

    // Shift-add multiples of the latched operand, all at result width.
    assign op_ext = OW'(op_q);
    assign x3     = op_ext + (op_ext << 1);
    assign x7     = (op_ext << 3) - op_ext;
    assign x8     = op_ext << 3;

    always_comb begin
        step_val = op_ext;
        unique case (phase_q)
            PH_X1:   step_val = x3;
            PH_X3:   step_val = x7;
            default: step_val = x8;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        out_d   = out_q;
        id_d    = id_q;
        gnt_d   = '0;
        launch  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                launch = arb_any;
            end
            S_RUN: begin
                if (accept) begin
                    if (phase_q != PH_X8) begin
                        phase_d = phase_e'(phase_q + 2'd1);
                        out_d   = step_val;
                    end else if (arb_any) begin
                        launch = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A launch presents phase 0 together with the grant pulse, so there is no bubble.
        if (launch) begin
            state_d = S_RUN;
            phase_d = PH_X1;
            op_d    = win_op;
            out_d   = OW'(win_op);
            id_d    = arb_idx;
            gnt_d   = arb_onehot;
            ptr_d   = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            phase_q <= PH_X1;
            ptr_q   <= '0;
            op_q    <= '0;
            out_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ptr_q   <= ptr_d;
            op_q    <= op_d;
            out_q   <= out_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign out_valid = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign out       = out_q;
    assign out_id    = id_q;
    assign out_phase = phase_q;

endmodule

// File: tb/tb_nowcode_mul_sched.sv
// Directed bench for nowcode_mul_sched: hand-computed result sequences per scenario.
module tb_nowcode_mul_sched;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int OW    = 11;
    localparam int IDW   = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N_REQ-1:0]    req = '0;
    logic [N_REQ*DW-1:0] d   = '0;
    logic                out_ready = 1'b1;
    logic [N_REQ-1:0]    gnt;
    logic                out_valid;
    logic [OW-1:0]       out;
    logic [IDW-1:0]      out_id;
    logic [1:0]          out_phase;
    logic                busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nowcode_mul_sched #(
        .N_REQ (N_REQ),
        .DW    (DW),
        .OW    (OW),
        .IDW   (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .d         (d),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_id    (out_id),
        .out_phase (out_phase),
        .busy      (busy)
    );

    function automatic int exp_mul(int v, int ph);
        case (ph)
            0:       return v;
            1:       return v * 3;
            2:       return v * 7;
            default: return v * 8;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({gnt, out_valid, out, out_id, out_phase, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_async got gnt=%b v=%b out=%0d id=%0d ph=%0d busy=%b exp all zero",
                     gnt, out_valid, out, out_id, out_phase, busy);
        end
        req = 4'b0001;
        d[0 +: DW] = 8'd100;
        @(negedge clk);
        checks++;
        if ({gnt, out_valid, busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_held got gnt=%b v=%b busy=%b exp 0000 0 0", gnt, out_valid, busy);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] eg;
        logic [OW-1:0]    eo;
        req = 4'b0001;
        d[0 +: DW] = 8'd100;
        out_ready = 1'b1;
        for (int ph = 0; ph < 4; ph++) begin
            @(negedge clk);
            eg = (ph == 0) ? 4'b0001 : 4'b0000;
            eo = OW'(exp_mul(100, ph));
            checks++;
            if ({gnt, out_valid, busy, out_id, out_phase, out} !== {eg, 1'b1, 1'b1, 2'd0, 2'(ph), eo}) begin
                errors++;
                $display("[TB] FAIL single ph=%0d got gnt=%b v=%b out=%0d id=%0d phase=%0d exp gnt=%b v=1 out=%0d id=0 phase=%0d",
                         ph, gnt, out_valid, out, out_id, out_phase, eg, eo, ph);
            end
            if (ph == 0) req = '0;
        end
        @(negedge clk);
        checks++;
        if ({gnt, out_valid, busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL single_idle got gnt=%b v=%b busy=%b exp 0000 0 0", gnt, out_valid, busy);
        end
    endtask

    task automatic test_contention();
        int order [5] = '{0, 1, 2, 3, 0};
        int vals  [4] = '{10, 20, 30, 40};
        int id;
        int ph;
        logic [N_REQ-1:0] eg;
        logic [OW-1:0]    eo;
        do_reset();
        for (int i = 0; i < N_REQ; i++) d[i*DW +: DW] = DW'(vals[i]);
        req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            id = order[k / 4];
            ph = k % 4;
            eg = '0;
            if (ph == 0) eg[id] = 1'b1;
            eo = OW'(exp_mul(vals[id], ph));
            checks++;
            if ({gnt, out_valid, busy, out_id, out_phase, out} !== {eg, 1'b1, 1'b1, IDW'(id), 2'(ph), eo}) begin
                errors++;
                $display("[TB] FAIL contention k=%0d got gnt=%b v=%b out=%0d id=%0d phase=%0d exp gnt=%b v=1 out=%0d id=%0d phase=%0d",
                         k, gnt, out_valid, out, out_id, out_phase, eg, eo, id, ph);
            end
        end
        req = '0;
        @(negedge clk);
        checks++;
        if ({gnt, out_valid, busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL contention_idle got gnt=%b v=%b busy=%b exp 0000 0 0", gnt, out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int eout [7] = '{255, 765, 765, 765, 765, 1785, 2040};
        int eph  [7] = '{0, 1, 1, 1, 1, 2, 3};
        logic [N_REQ-1:0] eg;
        d[1*DW +: DW] = 8'd255;
        req = 4'b0010;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            eg = (c == 0) ? 4'b0010 : 4'b0000;
            checks++;
            if ({gnt, out_valid, busy, out_id, out_phase, out} !== {eg, 1'b1, 1'b1, 2'd1, 2'(eph[c]), OW'(eout[c])}) begin
                errors++;
                $display("[TB] FAIL backpressure c=%0d got gnt=%b v=%b out=%0d id=%0d phase=%0d exp gnt=%b v=1 out=%0d id=1 phase=%0d",
                         c, gnt, out_valid, out, out_id, out_phase, eg, eout[c], eph[c]);
            end
            if (c == 0) req = '0;
            if (c == 1) out_ready = 1'b0;
            if (c == 4) out_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ({gnt, out_valid, busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_idle got gnt=%b v=%b busy=%b exp 0000 0 0", gnt, out_valid, busy);
        end
    endtask

    task automatic test_pointer_fairness();
        int id;
        int v;
        int ph;
        logic [N_REQ-1:0] eg;
        logic [OW-1:0]    eo;
        d[0*DW +: DW] = 8'd5;
        d[2*DW +: DW] = 8'd6;
        req = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            id = (k < 4) ? 2 : 0;
            v  = (k < 4) ? 6 : 5;
            ph = k % 4;
            eg = '0;
            if (ph == 0) eg[id] = 1'b1;
            eo = OW'(exp_mul(v, ph));
            checks++;
            if ({gnt, out_valid, busy, out_id, out_phase, out} !== {eg, 1'b1, 1'b1, IDW'(id), 2'(ph), eo}) begin
                errors++;
                $display("[TB] FAIL fairness k=%0d got gnt=%b v=%b out=%0d id=%0d phase=%0d exp gnt=%b v=1 out=%0d id=%0d phase=%0d",
                         k, gnt, out_valid, out, out_id, out_phase, eg, eo, id, ph);
            end
            if (k == 0) req = 4'b0001;
            if (k == 4) req = '0;
        end
        @(negedge clk);
        checks++;
        if ({gnt, out_valid, busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL fairness_idle got gnt=%b v=%b busy=%b exp 0000 0 0", gnt, out_valid, busy);
        end
    endtask

    task automatic test_boundary();
        int ids  [2] = '{1, 2};
        int vals [2] = '{0, 1};
        logic [N_REQ-1:0] eg;
        logic [OW-1:0]    eo;
        for (int s = 0; s < 2; s++) begin
            d[ids[s]*DW +: DW] = DW'(vals[s]);
            req = '0;
            req[ids[s]] = 1'b1;
            for (int ph = 0; ph < 4; ph++) begin
                @(negedge clk);
                eg = '0;
                if (ph == 0) eg[ids[s]] = 1'b1;
                eo = OW'(exp_mul(vals[s], ph));
                checks++;
                if ({gnt, out_valid, busy, out_id, out_phase, out} !== {eg, 1'b1, 1'b1, IDW'(ids[s]), 2'(ph), eo}) begin
                    errors++;
                    $display("[TB] FAIL boundary d=%0d ph=%0d got gnt=%b v=%b out=%0d id=%0d phase=%0d exp gnt=%b v=1 out=%0d id=%0d",
                             vals[s], ph, gnt, out_valid, out, out_id, out_phase, eg, eo, ids[s]);
                end
                if (ph == 0) req = '0;
            end
            @(negedge clk);
            checks++;
            if ({gnt, out_valid, busy} !== 6'b0) begin
                errors++;
                $display("[TB] FAIL boundary_idle d=%0d got gnt=%b v=%b busy=%b exp 0000 0 0", vals[s], gnt, out_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int eout [3] = '{50, 150, 350};
        logic [N_REQ-1:0] eg;
        d[2*DW +: DW] = 8'd50;
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            eg = (c == 0) ? 4'b0100 : 4'b0000;
            checks++;
            if ({gnt, out_valid, busy, out_id, out_phase, out} !== {eg, 1'b1, 1'b1, 2'd2, 2'(c), OW'(eout[c])}) begin
                errors++;
                $display("[TB] FAIL resetmid_pre c=%0d got gnt=%b v=%b out=%0d id=%0d phase=%0d exp gnt=%b v=1 out=%0d id=2 phase=%0d",
                         c, gnt, out_valid, out, out_id, out_phase, eg, eout[c], c);
            end
            if (c == 0) req = '0;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, out_valid, out, out_id, out_phase, busy} !== '0) begin
            errors++;
            $display("[TB] FAIL resetmid_async got gnt=%b v=%b out=%0d id=%0d ph=%0d busy=%b exp all zero",
                     gnt, out_valid, out, out_id, out_phase, busy);
        end
        #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({gnt, out_valid, busy} !== 6'b0) begin
                errors++;
                $display("[TB] FAIL resetmid_quiet c=%0d got gnt=%b v=%b busy=%b exp 0000 0 0", c, gnt, out_valid, busy);
            end
        end
        // Pointer must be back at 0: requester 0 wins over 3.
        d[0*DW +: DW] = 8'd7;
        d[3*DW +: DW] = 8'd9;
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if ({gnt, out_valid, out_id, out_phase, out} !== {4'b0001, 1'b1, 2'd0, 2'd0, 11'd7}) begin
            errors++;
            $display("[TB] FAIL resetmid_ptr got gnt=%b v=%b out=%0d id=%0d phase=%0d exp gnt=0001 v=1 out=7 id=0 phase=0",
                     gnt, out_valid, out, out_id, out_phase);
        end
        req = '0;
        repeat (4) @(negedge clk);
        checks++;
        if ({gnt, out_valid, busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL resetmid_end got gnt=%b v=%b busy=%b exp 0000 0 0", gnt, out_valid, busy);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_pointer_fairness();
        test_boundary();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nowcode_mul_sched.md
Name: nowcode_mul_sched

Overview:
- Round-robin scheduler that shares one sequential ×{1,3,7,8} shift-add multiplier among N_REQ requesters.
- Each granted operand (8-bit) produces four consecutive results: d×1, d×3, d×7, d×8.
- Results are tagged with requester id and phase and delivered over a valid/ready output handshake.
- Sits between the operand sources and the downstream result consumer. It replaces per-source copies of the multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, operand width.
- OW, 11, result width; must be ≥ DW+3.
- IDW, 2, id width; must equal clog2(N_REQ).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request; held until its gnt bit pulses.
- d  input  N_REQ*DW  packed operands; requester i uses d[i*DW +: DW]; valid while req[i]=1.
- gnt  output  N_REQ  one-hot, 1-cycle pulse; operand of that requester captured.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result when out_valid & out_ready.
- out  output  OW  result value.
- out_id  output  IDW  requester index owning out.
- out_phase  output  2  0:×1, 1:×3, 2:×7, 3:×8.
- busy  output  1  operand in flight (state RUN).

Behaviour:
- Reset (rst=0, asynchronous):
  - gnt=0, out_valid=0, out=0, out_id=0, out_phase=0, busy=0.
  - State=IDLE; round-robin pointer=0.
  - A sequence in flight is abandoned; its operand is lost and no partial results follow.
- States:
  - IDLE: no operand.
  - RUN: phase register p∈{0..3}.
- IDLE, req≠0 at an edge:
  - Winner w = first set bit of req searching from pointer upward, wrapping.
  - Next cycle: gnt=onehot(w) for exactly one cycle.
  - Operand d_q ← d[w], out_id ← w, p ← 0, out_valid=1, out=d_q, busy=1.
  - Pointer ← (w+1) mod N_REQ.
- RUN, edge with out_valid & out_ready:
  - p<3: p ← p+1 and out updates to the next multiple:
    - ×3 = d_q + (d_q<<1)
    - ×7 = (d_q<<3) − d_q
    - ×8 = d_q<<3
  - p=3 and req≠0: arbitrate immediately (back-to-back). gnt pulses and phase 0 of the new operand is presented the next cycle, with no bubble.
  - p=3 and req=0: out_valid ← 0, busy ← 0, state ← IDLE.
- Stall (out_valid & !out_ready): out, out_id and out_phase hold stable; no advance.
- Latency:
  - Grant-to-first-result is 0 cycles; gnt and phase-0 out_valid are coincident.
  - Four results need a minimum of 4 cycles.
- Width: all arithmetic is done at OW bits, zero-extended. The maximum 255×8 = 2040 fits 11 bits without overflow.
- req changes during RUN are ignored; the operand is already latched in d_q.
- A requester must deassert req or present a new operand the cycle after its gnt. If req stays high, it re-requests with the d then present.
- Simultaneous requests: exactly one grant per arbitration; the others wait.
- Starvation bound: a requester waits at most N_REQ−1 sequences.
- N_REQ=1 degenerates to a fixed grant.
- gnt is never asserted while a sequence is mid-phase (p<3, not accepted).

Decomposition:
- Shared package nowcode_mul_pkg holds:
  - phase enum PH_X1, PH_X3, PH_X7, PH_X8;
  - state enum S_IDLE, S_RUN;
  - default widths DW/OW.
- Sub-module nowcode_rr_arb: combinational rotate-priority pick over req given pointer. Outputs onehot and index; stateless.
- Pointer, FSM, multiplier datapath and output registers stay in nowcode_mul_sched.

Test Plan:
- Single requester: reset released at 20 ns, req=4'b0001, d[0]=100, out_ready=1.
  - gnt=0001 once.
  - out = 100, 300, 700, 800 on consecutive cycles, out_id=0, phases 0..3, then out_valid=0.
- Contention: req=1111 held, d[i]=10,20,30,40, out_ready=1.
  - Grant order 0,1,2,3,0, each back-to-back.
  - Requester 2 yields 30, 90, 210, 240.
  - No idle cycle between sequences.
- Backpressure: d=255, out_ready low for 3 cycles during phase 1.
  - out=765 with out_phase=1 held stable through the stall.
  - Then 1785, 2040 follow; no result is dropped or duplicated.
- Reset mid-operation: assert rst=0 while out_phase=2.
  - All outputs reach their reset values immediately, without waiting for a clock edge.
  - After release with req=0, out_valid stays 0.
- Pointer fairness: with the pointer at 2, assert req=0101.
  - Requester 2 is granted before requester 0.
  - Then, with req=0001 only, requester 0 is granted.
- Boundary operands: d=0 gives 0, 0, 0, 0; d=1 gives 1, 3, 7, 8.
